// File: rtl/kp_pkg.sv
// Shared types and helpers for the Karplus-Strong voice blocks.
// Exciter state encoding, LFSR constants and the noise scaler.
package kp_pkg;

  typedef enum logic {
    KP_EX_IDLE,
    KP_EX_BURST
  } kp_ex_state_e;

  localparam logic [31:0] KP_LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] KP_LFSR_SEED = 32'hACE1_0001;

  function automatic logic [31:0] kp_lfsr_step(
    input logic [31:0] s
  );
    return {1'b0, s[31:1]} ^ (s[0] ? KP_LFSR_TAPS : 32'h0);
  endfunction

  // Signed 24-bit noise times unsigned 7-bit velocity, /128.
  function automatic logic [23:0] kp_scale(
    input logic [23:0] x,
    input logic [6:0]  v
  );
    logic signed [31:0] xs;
    logic signed [31:0] vs;
    logic signed [31:0] p;
    xs = {{8{x[23]}}, x};
    vs = {25'd0, v};
    p  = xs * vs;
    p  = p >>> 7;
    return p[23:0];
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Trigger synchroniser, debouncer and press-edge strobe.
// trig is active-low; the held level is 1 while pressed.
module kp_debounce #(
  parameter int DEB_BITS = 2
) (
  input  logic audio_clk,
  input  logic reset_n,
  input  logic trig,
  output logic trig_pulse
);

  logic                s1;
  logic                s2;
  logic                held;
  logic [DEB_BITS-1:0] cnt;

  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      held       <= 1'b0;
      cnt        <= '0;
      trig_pulse <= 1'b0;
    end else begin
      s1         <= ~trig;
      s2         <= s1;
      trig_pulse <= 1'b0;
      if (s2 == held) begin
        cnt <= '0;
      end else if (&cnt) begin
        held       <= s2;
        cnt        <= '0;
        trig_pulse <= s2;
      end else begin
        cnt <= cnt + DEB_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/kp_exciter.sv
// Karplus-Strong exciter: free-running LFSR noise, gated into a
// velocity-scaled burst of delay_length samples on each press.
module kp_exciter
  import kp_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = KP_LFSR_SEED,
  parameter int          DEB_BITS  = 2
) (
  input  logic        audio_clk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [6:0]  velocity,
  input  logic [15:0] delay_length,
  output logic [23:0] dnoise,
  output logic        burst_active,
  output logic        trig_pulse
);

  kp_ex_state_e state;
  kp_ex_state_e state_n;
  logic [31:0]  lfsr;
  logic [6:0]   vel_l;
  logic [6:0]   vel_n;
  logic [15:0]  len_l;
  logic [15:0]  len_n;
  logic [15:0]  remain;
  logic [15:0]  remain_n;

  kp_debounce #(
    .DEB_BITS (DEB_BITS)
  ) u_deb (
    .audio_clk  (audio_clk),
    .reset_n    (reset_n),
    .trig       (trig),
    .trig_pulse (trig_pulse)
  );

  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= kp_lfsr_step(lfsr);
  end

  // A press wins over the running count, so retriggers restart it.
  always_comb begin
    state_n  = state;
    vel_n    = vel_l;
    len_n    = len_l;
    remain_n = remain;
    if (trig_pulse) begin
      vel_n    = velocity;
      len_n    = delay_length;
      remain_n = delay_length;
      state_n  = (delay_length == 16'd0) ? KP_EX_IDLE : KP_EX_BURST;
    end else if (state == KP_EX_BURST) begin
      remain_n = remain - 16'd1;
      if (remain == 16'd1) state_n = KP_EX_IDLE;
    end
  end

  always_ff @(posedge audio_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= KP_EX_IDLE;
      vel_l        <= '0;
      len_l        <= '0;
      remain       <= '0;
      dnoise       <= '0;
      burst_active <= 1'b0;
    end else begin
      state        <= state_n;
      vel_l        <= vel_n;
      len_l        <= len_n;
      remain       <= remain_n;
      burst_active <= (state == KP_EX_BURST);
      dnoise       <= (state == KP_EX_BURST) ?
                      kp_scale(lfsr[23:0], vel_l) : 24'd0;
    end
  end

endmodule
